// File: rtl/run_monitor_pkg.sv
// Shared types and default parameters for the run controller / memory dumper.
package run_monitor_pkg;

    typedef enum logic [2:0] {
        RM_IDLE,
        RM_RUN,
        RM_DRAIN,
        RM_DUMP,
        RM_DONE
    } rm_state_e;

    localparam int unsigned RM_ADDR_W          = 9;
    localparam int unsigned RM_DATA_W          = 32;
    localparam int unsigned RM_CNT_W           = 16;
    localparam int unsigned RM_TIMEOUT_CYCLES  = 300;
    localparam int unsigned RM_DRAIN_CYCLES    = 2;
    localparam bit          RM_DUMP_ON_TIMEOUT = 1'b0;
    localparam int unsigned RM_FIFO_DEPTH      = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with a registered head word, so the stream payload comes straight from flops.
module skid_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; head only moves when it is consumed.
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (count != 2'd0);

endmodule

// File: rtl/run_monitor.sv
// Run controller: counts RUN cycles, catches the finish edge or a watchdog timeout, halts the CPU
// and streams the whole data memory out over a valid/ready port.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned ADDR_W          = RM_ADDR_W,
    parameter int unsigned DATA_W          = RM_DATA_W,
    parameter int unsigned CNT_W           = RM_CNT_W,
    parameter int unsigned TIMEOUT_CYCLES  = RM_TIMEOUT_CYCLES,
    parameter int unsigned DRAIN_CYCLES    = RM_DRAIN_CYCLES,
    parameter bit          DUMP_ON_TIMEOUT = RM_DUMP_ON_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    output logic              halt,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycles
);

    localparam int unsigned FW      = DATA_W + ADDR_W + 1;
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = '1;

    rm_state_e            state;
    logic                 finish_q;
    logic                 finish_edge;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [ADDR_W-1:0]    addr_q;
    logic                 issue_done_q;
    logic                 rd_pending_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic                 rd_last_q;
    logic                 issue;
    logic                 fifo_pop;
    logic [1:0]           fifo_count;
    logic [FW-1:0]        fifo_head;

    assign finish_edge = finish & ~finish_q;

    // Credit check: a word popped this cycle frees its slot for a read issued this cycle.
    always_comb begin
        fifo_pop = dump_valid & dump_ready;
        issue    = 1'b0;
        if (state == RM_DUMP && !issue_done_q) begin
            issue = (({1'b0, fifo_count} + {2'b00, rd_pending_q}) <
                     (3'(RM_FIFO_DEPTH) + {2'b00, fifo_pop}));
        end
    end

    assign mem_ren   = issue;
    assign mem_raddr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RM_IDLE;
            finish_q     <= 1'b0;
            cycles       <= '0;
            done         <= 1'b0;
            timed_out    <= 1'b0;
            halt         <= 1'b0;
            drain_cnt    <= '0;
            addr_q       <= '0;
            issue_done_q <= 1'b0;
            rd_pending_q <= 1'b0;
            rd_addr_q    <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            rd_pending_q <= issue;
            rd_addr_q    <= addr_q;
            rd_last_q    <= (addr_q == LAST_ADDR);

            unique case (state)
                RM_IDLE, RM_DONE: begin
                    if (start) begin
                        state     <= RM_RUN;
                        cycles    <= '0;
                        done      <= 1'b0;
                        timed_out <= 1'b0;
                        halt      <= 1'b0;
                        // Arm with the current level so a finish already high is not an edge.
                        finish_q  <= finish;
                    end
                end
                RM_RUN: begin
                    finish_q <= finish;
                    if (cycles != '1) cycles <= cycles + 1'b1;
                    if (finish_edge) begin
                        state     <= RM_DRAIN;
                        halt      <= 1'b1;
                        drain_cnt <= '0;
                    end else if (cycles == TIMEOUT_LAST) begin
                        timed_out <= 1'b1;
                        halt      <= 1'b1;
                        if (DUMP_ON_TIMEOUT) begin
                            state     <= RM_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state <= RM_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RM_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state        <= RM_DUMP;
                        addr_q       <= '0;
                        issue_done_q <= 1'b0;
                    end
                end
                RM_DUMP: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == LAST_ADDR) issue_done_q <= 1'b1;
                    end
                    if (fifo_pop && dump_last) begin
                        state <= RM_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= RM_IDLE;
            endcase
        end
    end

    skid_fifo2 #(
        .WIDTH(FW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pending_q),
        .push_data({mem_rdata, rd_addr_q, rd_last_q}),
        .pop      (fifo_pop),
        .valid    (dump_valid),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign {dump_data, dump_addr, dump_last} = fifo_head;

endmodule

// File: tb/tb_run_monitor.sv
// Directed and randomized runs of run_monitor against a cycle-level reference of run/dump rules.
module tb_run_monitor;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 20;
    localparam int unsigned DR = 2;
    localparam int unsigned NW = 1 << AW;
    localparam int unsigned PW = DW + AW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, finish, dump_ready;
    logic          halt, mem_ren, dump_valid, dump_last, done, timed_out;
    logic [AW-1:0] mem_raddr, dump_addr;
    logic [DW-1:0] mem_rdata, dump_data;
    logic [CW-1:0] cycles;

    logic          start1, finish1, dump_ready1;
    logic          halt1, mem_ren1, dump_valid1, dump_last1, done1, timed_out1;
    logic [AW-1:0] mem_raddr1, dump_addr1;
    logic [DW-1:0] mem_rdata1, dump_data1;
    logic [CW-1:0] cycles1;

    logic [DW-1:0] mem [NW];
    logic [59:0]   outs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren)  mem_rdata  <= mem[mem_raddr];
        if (mem_ren1) mem_rdata1 <= mem[mem_raddr1];
    end

    assign outs = {halt, mem_ren, mem_raddr, dump_valid, dump_data, dump_addr, dump_last,
                   done, timed_out, cycles};

    run_monitor #(
        .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(TO),
        .DRAIN_CYCLES(DR), .DUMP_ON_TIMEOUT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish), .halt(halt),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_addr(dump_addr), .dump_last(dump_last), .done(done),
        .timed_out(timed_out), .cycles(cycles)
    );

    run_monitor #(
        .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(TO),
        .DRAIN_CYCLES(DR), .DUMP_ON_TIMEOUT(1'b1)
    ) dut_dot (
        .clk(clk), .rst(rst), .start(start1), .finish(finish1), .halt(halt1),
        .mem_ren(mem_ren1), .mem_raddr(mem_raddr1), .mem_rdata(mem_rdata1),
        .dump_valid(dump_valid1), .dump_ready(dump_ready1), .dump_data(dump_data1),
        .dump_addr(dump_addr1), .dump_last(dump_last1), .done(done1),
        .timed_out(timed_out1), .cycles(cycles1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Level of finish sampled at the edge ending RUN cycle k (k=0 is the start edge).
    function automatic logic fin_level(input int k, input bit pre, input int fall, input int rise);
        if (k == 0) return pre;
        if (pre && k < fall) return 1'b1;
        if (rise > 0 && k >= rise) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_run(input string tag, input bit pre, input int fall, input int rise,
                          input int mode, input int rst_after);
        int            end_k;
        bit            edge_seen;
        bit            quiet;
        bit            fin;
        bit            stalled;
        int            n_hs, n_ren, first_hs, last_hs;
        logic [PW-1:0] q [$];
        logic [PW-1:0] held;
        logic [PW-1:0] expw;

        end_k     = TO;
        edge_seen = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            if (!edge_seen && fin_level(k, pre, fall, rise) && !fin_level(k - 1, pre, fall, rise))
            begin
                end_k     = k;
                edge_seen = 1'b1;
            end
        end
        for (int a = 0; a < NW; a++) q.push_back({mem[a], AW'(a), a == NW - 1});

        finish = fin_level(0, pre, fall, rise);
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "/entry_clear"}, {done, timed_out, halt, cycles}, 64'd0);

        for (int k = 1; k <= end_k; k++) begin
            finish = fin_level(k, pre, fall, rise);
            @(posedge clk); #1;
            if (k == 1 && end_k > 1) chk({tag, "/cycles1"}, cycles, 1);
            if (k == end_k - 1) chk({tag, "/halt_in_run"}, halt, 0);
        end
        finish = 1'b0;
        chk({tag, "/cycles"}, cycles, end_k);
        chk({tag, "/timed_out"}, timed_out, !edge_seen);
        chk({tag, "/halt"}, halt, 1);

        if (!edge_seen) begin
            chk({tag, "/done_timeout"}, done, 1);
            quiet = 1'b1;
            for (int c = 0; c < 12; c++) begin
                if (mem_ren || dump_valid) quiet = 1'b0;
                @(posedge clk); #1;
            end
            chk({tag, "/no_dump"}, quiet, 1);
            return;
        end

        for (int d = 0; d < DR; d++) begin
            chk({tag, "/drain_no_ren"}, mem_ren, 0);
            @(posedge clk); #1;
        end
        chk({tag, "/first_ren"}, mem_ren, 1);

        n_hs = 0; n_ren = 0; first_hs = -1; last_hs = -1;
        stalled = 1'b0; fin = 1'b0; held = '0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (mode == 0)      dump_ready = 1'b1;
            else if (mode == 1) dump_ready = (c % 3 == 0);
            else                dump_ready = 1'($urandom_range(0, 1));
            #1;
            if (mem_ren) n_ren++;
            chk({tag, "/fifo_occ"}, dut.fifo_count <= 2'd2, 1);
            if (stalled) begin
                chk({tag, "/stall_hold"}, {dump_valid, dump_data, dump_addr, dump_last},
                    {1'b1, held});
            end
            if (dump_valid && dump_ready) begin
                chk({tag, "/word_expected"}, q.size() > 0, 1);
                if (q.size() > 0) begin
                    expw = q.pop_front();
                    chk({tag, "/word"}, {dump_data, dump_addr, dump_last}, expw);
                end
                if (dump_last) begin
                    chk({tag, "/done_before_last"}, done, 0);
                    fin = 1'b1;
                end
                n_hs++;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                if (n_hs == rst_after) begin
                    @(posedge clk); #1;
                    rst = 1'b1;
                    #1;
                    chk({tag, "/rst_outs"}, outs, 64'd0);
                    @(posedge clk); #1;
                    chk({tag, "/rst_outs_clk"}, outs, 64'd0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    dump_ready = 1'b0;
                    return;
                end
            end
            stalled = dump_valid && !dump_ready;
            held    = {dump_data, dump_addr, dump_last};
            @(posedge clk); #1;
        end
        chk({tag, "/hs_count"}, n_hs, NW);
        chk({tag, "/ren_count"}, n_ren, NW);
        chk({tag, "/done"}, done, 1);
        chk({tag, "/halt_done"}, halt, 1);
        chk({tag, "/valid_off"}, dump_valid, 0);
        if (mode == 0) chk({tag, "/back_to_back"}, last_hs - first_hs, NW - 1);
    endtask

    initial begin
        int  n;
        bit  fin;

        start = 1'b0; finish = 1'b0; dump_ready = 1'b0;
        start1 = 1'b0; finish1 = 1'b0; dump_ready1 = 1'b1;
        rst = 1'b0;
        for (int a = 0; a < NW; a++) mem[a] = 32'hA0 + a;
        #1 rst = 1'b1;
        #1;
        chk("reset_outs", outs, 64'd0);
        @(posedge clk); #1;
        chk("reset_outs_clk", outs, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_run("basic",     1'b0, 0, 7,  0, 0);
        do_run("timeout",   1'b0, 0, 0,  0, 0);
        do_run("stall",     1'b0, 0, 5,  1, 0);
        do_run("tie",       1'b0, 0, 20, 0, 0);
        do_run("rst_mid",   1'b0, 0, 6,  0, 3);
        do_run("after_rst", 1'b0, 0, 4,  0, 0);
        do_run("held_high", 1'b1, 3, 9,  0, 0);

        // Timed-out run on the dump-on-timeout instance still drains memory.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0; fin = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (dump_valid1) begin
                chk("dot/word", {dump_data1, dump_addr1, dump_last1},
                    {mem[n % NW], AW'(n), n == NW - 1});
                n++;
                if (dump_last1) fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("dot/count", n, NW);
        chk("dot/timed_out", timed_out1, 1);
        chk("dot/done", done1, 1);
        chk("dot/cycles", cycles1, TO);

        for (int i = 0; i < 4; i++) begin
            for (int a = 0; a < NW; a++) mem[a] = $urandom;
            do_run("rand", 1'b0, 0, int'($urandom_range(1, 24)), 2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
